pllvr_reconfig_ctrl: RTL and testbench
======================================

// Module: pllvr_reconfig_ctrl
// PURPOSE
// - Sequencer for Gowin PLLVR dynamic divider reconfiguration (IDSEL/FBDSEL/ODSEL).
// - Accepts divider-change requests, holds PLL in reset while codes change, waits for filtered lock.
// - Retries on lock timeout, re-locks automatically on loss of lock, reports done/error.
// - Sits between user logic and a PLLVR instance whose DYN_*DIV_SEL are "true".
// PARAMETERS
// DIV_W        6      width of idiv/fdiv/odiv codes (PLLVR IDSEL/FBDSEL/ODSEL width)
// INIT_IDIV    6'd5   IDSEL code driven out of reset
// INIT_FDIV    6'd12  FBDSEL code driven out of reset
// INIT_ODIV    6'd8   ODSEL code driven out of reset
// RST_HOLD     16     cycles pll_reset held high per attempt (>=1)
// LOCK_STABLE  64     consecutive synced-lock-high cycles required to declare lock (>=1)
// LOCK_TIMEOUT 65535  cycles in WAIT_LOCK before an attempt counts as failed
// MAX_RETRY    3      extra attempts after the first before FAIL (0 = no retry)
// PORTS
// clk          in   1      system clock
// resetn       in   1      asynchronous active-low reset
// req_valid    in   1      request new divider codes
// req_ready    out  1      high in IDLE and FAIL only
// req_idiv     in   DIV_W  requested IDSEL code
// req_fdiv     in   DIV_W  requested FBDSEL code
// req_odiv     in   DIV_W  requested ODSEL code
// pll_lock     in   1      PLLVR LOCK (asynchronous to clk)
// pll_reset    out  1      to PLLVR RESET
// pll_idsel    out  DIV_W  to PLLVR IDSEL
// pll_fbdsel   out  DIV_W  to PLLVR FBDSEL
// pll_odsel    out  DIV_W  to PLLVR ODSEL
// locked       out  1      high only in IDLE after successful lock
// busy         out  1      high in RST and WAIT_LOCK
// done         out  1      1-cycle pulse on WAIT_LOCK->IDLE
// err          out  1      1-cycle pulse on WAIT_LOCK->FAIL
// lol          out  1      1-cycle pulse when lock lost in IDLE
// BEHAVIOUR
// - Reset: state=RST, pll_reset=1, codes=INIT_*, locked/done/err/lol=0, busy=1, counters=0, retry=0.
// - pll_lock through 2-FF synchroniser (lock_s); all decisions use lock_s.
// - RST: pll_reset=1 for exactly RST_HOLD cycles, then WAIT_LOCK with pll_reset=0.
// - WAIT_LOCK: stable ctr +1 when lock_s=1, cleared when lock_s=0; timeout ctr +1 every cycle.
//   stable==LOCK_STABLE -> IDLE, done=1, retry=0 (stable wins if both reach limit same cycle).
//   timeout==LOCK_TIMEOUT: retry<MAX_RETRY -> retry+1, RST; else FAIL, err=1.
// - IDLE: locked=1. lock_s=0 -> lol=1, locked=0, RST with same codes, retry=0.
// - Accept = req_valid & req_ready. On accept edge: codes<=req_*, pll_reset<=1, state<=RST, retry<=0,
//   counters cleared; locked drops the same edge. Codes change only together with pll_reset rising.
// - FAIL: pll_reset=1 held, locked=0, busy=0; leaves only on accepted request.
// - req_valid while busy is ignored (no queueing); requester holds valid until ready.
// - Counters saturate-safe: widths sized by $clog2 of their limits; no wrap.
// - resetn mid-sequence: immediate return to reset values, bring-up restarts with INIT_* codes.
// TESTING (bench params: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2)
// - Bring-up: release resetn, pll_lock=1 from cycle 10 -> pll_reset high 4 cycles, done once, locked=1, codes 5/12/8.
// - Request idiv=3 fdiv=20 odiv=4 in IDLE -> next edge codes=3/20/4 & pll_reset=1, locked=0; done after relock.
// - Lock glitch: pll_lock low 1 cycle at stable=5 -> stable ctr restarts; done only after 8 clean cycles.
// - pll_lock stuck 0 -> 3 attempts (3 pll_reset pulses), then err pulse, FAIL, req_ready=1; new request restarts.
// - Lose lock in IDLE -> lol pulse, locked=0, pll_reset pulse, codes unchanged, done on relock.
// - req_valid during WAIT_LOCK -> req_ready=0, no code change; resetn low mid-WAIT_LOCK -> codes back to INIT.

Source files
------------

// File: rtl/pllvr_reconfig_ctrl.sv
// Sequencer for Gowin PLLVR dynamic divider reconfiguration: holds the PLL in
// reset while IDSEL/FBDSEL/ODSEL change, waits for filtered lock, retries on timeout.
module pllvr_reconfig_ctrl #(
  parameter int DIV_W = 6,
  parameter logic [DIV_W-1:0] INIT_IDIV = DIV_W'(5),
  parameter logic [DIV_W-1:0] INIT_FDIV = DIV_W'(12),
  parameter logic [DIV_W-1:0] INIT_ODIV = DIV_W'(8),
  parameter int RST_HOLD = 16,
  parameter int LOCK_STABLE = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_idiv,
  input  logic [DIV_W-1:0] req_fdiv,
  input  logic [DIV_W-1:0] req_odiv,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [DIV_W-1:0] pll_idsel,
  output logic [DIV_W-1:0] pll_fbdsel,
  output logic [DIV_W-1:0] pll_odsel,
  output logic             locked,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             lol
);

  localparam int HOLD_W  = $clog2(RST_HOLD + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  // Encoding puts pll_reset directly on a flop bit (bit 1) so the PLL reset never glitches.
  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RST  = 2'b10,
    ST_FAIL = 2'b11
  } state_t;

  state_t state;
  state_t state_next;

  logic               lock_meta;
  logic               lock_s;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [STAB_W-1:0]  stable_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RETRY_W-1:0] retry_cnt;

  logic accept;
  logic hold_end;
  logic stable_hit;
  logic timeout_hit;
  logic retry_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign accept      = req_valid & req_ready;
  assign hold_end    = (hold_cnt == HOLD_LAST);
  assign stable_hit  = lock_s && (stable_cnt == STAB_LAST);
  assign timeout_hit = (tmo_cnt == TMO_LAST);
  assign retry_ok    = (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_RST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RST:  if (hold_end) state_next = ST_WAIT;
      ST_WAIT: begin
        if (stable_hit) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          state_next = retry_ok ? ST_RST : ST_FAIL;
        end
      end
      ST_IDLE: if (accept || !lock_s) state_next = ST_RST;
      ST_FAIL: if (accept) state_next = ST_RST;
      default: state_next = ST_RST;
    endcase
  end

  always_comb begin
    pll_reset = state[1];
    busy      = ~state[0];
    req_ready = state[0];
    locked    = (state == ST_IDLE);
  end

  // Counters are cleared on every exit from their state, so they never pass their limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt   <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      pll_idsel  <= INIT_IDIV;
      pll_fbdsel <= INIT_FDIV;
      pll_odsel  <= INIT_ODIV;
      done       <= 1'b0;
      err        <= 1'b0;
      lol        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      lol  <= 1'b0;
      case (state)
        ST_RST: hold_cnt <= hold_end ? '0 : hold_cnt + 1'b1;
        ST_WAIT: begin
          if (stable_hit) begin
            done      <= 1'b1;
            retry_cnt <= '0;
          end else if (timeout_hit) begin
            if (retry_ok) retry_cnt <= retry_cnt + 1'b1;
            else          err       <= 1'b1;
          end
          if (stable_hit || timeout_hit) begin
            stable_cnt <= '0;
            tmo_cnt    <= '0;
          end else begin
            stable_cnt <= lock_s ? stable_cnt + 1'b1 : '0;
            tmo_cnt    <= tmo_cnt + 1'b1;
          end
        end
        ST_IDLE, ST_FAIL: begin
          if (accept) begin
            pll_idsel  <= req_idiv;
            pll_fbdsel <= req_fdiv;
            pll_odsel  <= req_odiv;
            retry_cnt  <= '0;
            hold_cnt   <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
          end else if (state == ST_IDLE && !lock_s) begin
            lol       <= 1'b1;
            retry_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pllvr_reconfig_ctrl.sv
// Randomized bench for pllvr_reconfig_ctrl: an attempt/event-level model predicts
// the status and code outputs after every clock edge from the stimulus timeline.
module tb_pllvr_reconfig_ctrl;

  localparam int N    = 3200;
  localparam int H    = 4;
  localparam int LS   = 8;
  localparam int T    = 100;
  localparam int MAXR = 2;
  localparam logic [17:0] INIT = {6'd5, 6'd12, 6'd8};

  // status vector: {req_ready, pll_reset, busy, locked, done, err, lol}
  localparam logic [6:0] O_RST  = 7'b0110000;
  localparam logic [6:0] O_WAIT = 7'b0010000;
  localparam logic [6:0] O_IDLE = 7'b1001000;
  localparam logic [6:0] O_FAIL = 7'b1100000;
  localparam logic [6:0] P_DONE = 7'b0000100;
  localparam logic [6:0] P_ERR  = 7'b0000010;
  localparam logic [6:0] P_LOL  = 7'b0000001;

  typedef struct {
    int          issue;
    logic [17:0] c;
  } req_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_idiv = '0;
  logic [5:0] req_fdiv = '0;
  logic [5:0] req_odiv = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       locked;
  logic       busy;
  logic       done;
  logic       err;
  logic       lol;

  pllvr_reconfig_ctrl #(
    .DIV_W(6), .INIT_IDIV(6'd5), .INIT_FDIV(6'd12), .INIT_ODIV(6'd8),
    .RST_HOLD(H), .LOCK_STABLE(LS), .LOCK_TIMEOUT(T), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fdiv(req_fdiv), .req_odiv(req_odiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .locked(locked), .busy(busy), .done(done), .err(err), .lol(lol)
  );

  always #5 clk = ~clk;

  // stimulus per edge n (value present at posedge n) and expectations after edge n
  logic        lk[N];
  logic        rn[N];
  logic        rv[N];
  logic [17:0] rc[N];
  logic [6:0]  eo[N];
  logic [17:0] ec[N];
  logic [6:0]  go[N];
  logic [17:0] gc[N];
  req_t        rq[$];
  logic [17:0] m_codes;
  int          m_retry;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cur, got, exp);
    end
  endtask

  function automatic void add_req(int issue, logic [17:0] c);
    req_t r;
    r.issue = issue;
    r.c = c;
    rq.push_back(r);
  endfunction

  function automatic void emit(int n, logic [6:0] o, logic [17:0] c);
    if (n >= N) return;
    eo[n] = o;
    ec[n] = c;
    if (rq.size() > 0 && rq[0].issue <= n) begin
      rv[n] = 1'b1;
      rc[n] = rq[0].c;
    end else begin
      rv[n] = 1'b0;
      rc[n] = 18'($urandom);
    end
  endfunction

  // 8 consecutive high synchronised samples ending at decision edge x (lock_s = lk[x-2])
  function automatic bit run_high(int x);
    if (x >= N) return 1'b0;
    for (int k = 0; k < LS; k++) if (!lk[x - 2 - k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int reset_span(int r);
    int q = r;
    while (q < N && !rn[q]) begin
      emit(q, O_RST, INIT);
      q++;
    end
    m_codes = INIT;
    m_retry = 0;
    return q - 1;
  endfunction

  // Idle or failed: scan for reset, an accepted request, or (idle only) loss of lock.
  function automatic int scan_ready(int f0, bit idle);
    for (int f = f0; f < N; f++) begin
      if (!rn[f]) return reset_span(f);
      if (rq.size() > 0 && rq[0].issue <= f) begin
        m_codes = rq[0].c;
        m_retry = 0;
        emit(f, O_RST, m_codes);
        void'(rq.pop_front());
        return f;
      end
      if (idle && !lk[f - 2]) begin
        m_retry = 0;
        emit(f, O_RST | P_LOL, m_codes);
        return f;
      end
      emit(f, idle ? O_IDLE : O_FAIL, m_codes);
    end
    return N;
  endfunction

  // Each attempt: RST for H observations, then up to T lock decisions; s is the entry edge.
  task automatic build_model();
    int s, e, t, stop, r;
    s = reset_span(0);
    while (s < N - 1) begin
      e = -1;
      t = s + H + T;
      for (int x = s + H + LS; x <= t && e < 0; x++) if (run_high(x)) e = x;
      stop = (e >= 0) ? e : t;
      r = -1;
      for (int n = s + 1; n < stop && n < N && r < 0; n++) begin
        if (!rn[n]) r = n;
        else emit(n, (n < s + H) ? O_RST : O_WAIT, m_codes);
      end
      if (r >= 0) s = reset_span(r);
      else if (stop >= N) s = N;
      else if (!rn[stop]) s = reset_span(stop);
      else if (e >= 0) begin
        m_retry = 0;
        emit(e, O_IDLE | P_DONE, m_codes);
        s = scan_ready(e + 1, 1'b1);
      end else if (m_retry < MAXR) begin
        m_retry++;
        emit(t, O_RST, m_codes);
        s = t;
      end else begin
        emit(t, O_FAIL | P_ERR, m_codes);
        s = scan_ready(t + 1, 1'b0);
      end
    end
  endtask

  task automatic build_stim();
    int z0, r0;
    for (int n = 0; n < N; n++) begin
      lk[n] = 1'b1; rn[n] = 1'b1; rv[n] = 1'b0; rc[n] = '0; eo[n] = '0; ec[n] = '0;
    end
    for (int n = 0; n <= 4; n++) rn[n] = 1'b0;
    for (int n = 0; n < 10; n++) lk[n] = 1'b0;
    add_req(150, {6'd3, 6'd20, 6'd4});
    for (int n = 151; n <= 154; n++) lk[n] = 1'b0;
    add_req(300, 18'($urandom));
    for (int n = 301; n <= 304; n++) lk[n] = 1'b0;
    lk[310] = 1'b0;
    add_req(600, 18'($urandom));
    for (int n = 601; n <= 1004; n++) lk[n] = 1'b0;
    add_req(1000, 18'($urandom));
    lk[1150] = 1'b0;
    add_req(1300, 18'($urandom));
    for (int n = 1301; n <= 1304; n++) lk[n] = 1'b0;
    add_req(1310, 18'($urandom));
    add_req(1500, 18'($urandom));
    for (int n = 1501; n <= 1540; n++) lk[n] = 1'b0;
    for (int n = 1520; n <= 1523; n++) rn[n] = 1'b0;
    for (int n = 1700; n < N; n++) lk[n] = ($urandom_range(0, 99) < 97);
    z0 = 2300 + int'($urandom_range(0, 60));
    for (int n = z0; n < z0 + 350; n++) lk[n] = 1'b0;
    for (int k = 0; k < 10; k++) add_req(1700 + 140 * k + int'($urandom_range(0, 60)), 18'($urandom));
    r0 = 2900 + int'($urandom_range(0, 40));
    for (int n = r0; n < r0 + 3; n++) rn[n] = 1'b0;
  endtask

  task automatic drive(int n);
    pll_lock  = lk[n];
    resetn    = rn[n];
    req_valid = rv[n];
    {req_idiv, req_fdiv, req_odiv} = rc[n];
  endtask

  function automatic int count_bit(int lo, int hi, int b);
    int c = 0;
    for (int n = lo; n <= hi; n++) if (go[n][b]) c++;
    return c;
  endfunction

  function automatic int count_rise(int lo, int hi, int b);
    int c = 0;
    for (int n = lo; n <= hi; n++) if (go[n][b] && !go[n - 1][b]) c++;
    return c;
  endfunction

  initial begin
    build_stim();
    m_codes = INIT;
    m_retry = 0;
    build_model();
    drive(0);
    for (int n = 0; n < N; n++) begin
      @(posedge clk);
      @(negedge clk);
      cur = n;
      go[n] = {req_ready, pll_reset, busy, locked, done, err, lol};
      gc[n] = {pll_idsel, pll_fbdsel, pll_odsel};
      check("status", 32'(go[n]), 32'(eo[n]));
      check("codes", 32'(gc[n]), 32'(ec[n]));
      if (n > 0 && rv[n] && eo[n - 1][6])
        $display("txn cycle=%0d accept codes=%h", n, rc[n]);
      if (eo[n][2]) $display("txn cycle=%0d done codes=%h", n, ec[n]);
      if (eo[n][1]) $display("txn cycle=%0d err codes=%h", n, ec[n]);
      if (eo[n][0]) $display("txn cycle=%0d lol codes=%h", n, ec[n]);
      if (n + 1 < N) drive(n + 1);
    end
    cur = N;
    check("reset_status", 32'(go[0]), 32'(O_RST));
    check("reset_codes", 32'(gc[0]), 32'(INIT));
    check("bringup_done_count", 32'(count_bit(0, 149, 2)), 32'd1);
    check("bringup_locked", 32'(go[100][3]), 32'd1);
    check("bringup_codes", 32'(gc[100]), 32'(INIT));
    check("req1_codes", 32'(gc[150]), 32'({6'd3, 6'd20, 6'd4}));
    check("req1_reset", 32'(go[150][5]), 32'd1);
    check("req1_locked_drop", 32'(go[150][3]), 32'd0);
    check("glitch_done_count", 32'(count_bit(300, 320, 2)), 32'd1);
    check("stuck_reset_pulses", 32'(count_rise(600, 911, 5)), 32'd3);
    check("stuck_err_count", 32'(count_bit(600, 999, 1)), 32'd1);
    check("fail_ready", 32'(go[950][6]), 32'd1);
    check("fail_reset_held", 32'(go[950][5]), 32'd1);
    check("lol_count", 32'(count_bit(1100, 1199, 0)), 32'd1);
    check("lol_codes_kept", 32'(gc[1160]), 32'(gc[1140]));
    check("wait_req_ignored", 32'(gc[1312]), 32'(gc[1301]));
    check("midreset_codes", 32'(gc[1530]), 32'(INIT));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
